// File: rtl/controller_pio_pkg.sv
// controller_pio_pkg
// Shared definitions for controller_pio_ext and its edge-capture block:
//   - Avalon word addresses of the eight registers
//   - capture-edge selector values for the EDGE_TYPE parameter
//   - state encoding of the one-shot pulse engine
package controller_pio_pkg;

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_OUT     = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP = 3'd3;
  localparam logic [2:0] ADDR_SET     = 3'd4;
  localparam logic [2:0] ADDR_CLR     = 3'd5;
  localparam logic [2:0] ADDR_TGL     = 3'd6;
  localparam logic [2:0] ADDR_PULSE   = 3'd7;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  typedef enum logic {
    PULSE_IDLE,
    PULSE_ACTIVE
  } pulse_state_t;

endpackage

// File: rtl/controller_pio_ext_edge_capture.sv
// pio_edge_capture
// Input side of the PIO: synchroniser chain, edge detector, write-1-to-clear
// capture register, interrupt mask and the registered level interrupt.
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   in_port      asynchronous inputs
//   mask_we      load irq_mask from wdata this cycle
//   cap_w1c_we   clear edge_cap bits where wdata is 1 this cycle
//   wdata        write data (IN_WIDTH bits)
//   in_sync      synchronised inputs
//   irq_mask     current interrupt mask
//   edge_cap     captured edges
//   irq          registered level interrupt
module pio_edge_capture
  import controller_pio_pkg::*;
#(
  parameter int IN_WIDTH    = 8,
  parameter int EDGE_TYPE   = EDGE_RISING,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IN_WIDTH-1:0] in_port,
  input  logic                mask_we,
  input  logic                cap_w1c_we,
  input  logic [IN_WIDTH-1:0] wdata,
  output logic [IN_WIDTH-1:0] in_sync,
  output logic [IN_WIDTH-1:0] irq_mask,
  output logic [IN_WIDTH-1:0] edge_cap,
  output logic                irq
);

  logic [SYNC_STAGES-1:0][IN_WIDTH-1:0] sync_reg;
  logic [IN_WIDTH-1:0] in_prev_reg;
  logic [IN_WIDTH-1:0] edge_cap_reg, edge_cap_next;
  logic [IN_WIDTH-1:0] irq_mask_reg, irq_mask_next;
  logic [IN_WIDTH-1:0] edge_hit;
  logic                irq_reg;

  assign in_sync = sync_reg[SYNC_STAGES-1];

  always_comb begin
    case (EDGE_TYPE)
      EDGE_FALLING: edge_hit = ~in_sync & in_prev_reg;
      EDGE_ANY:     edge_hit = in_sync ^ in_prev_reg;
      default:      edge_hit = in_sync & ~in_prev_reg;
    endcase
  end

  // The OR with edge_hit comes last so a fresh edge survives a same-cycle W1C.
  always_comb begin
    edge_cap_next = (edge_cap_reg & ~(cap_w1c_we ? wdata : '0)) | edge_hit;
    irq_mask_next = mask_we ? wdata : irq_mask_reg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_reg     <= '0;
      in_prev_reg  <= '0;
      edge_cap_reg <= '0;
      irq_mask_reg <= '0;
      irq_reg      <= 1'b0;
    end else begin
      sync_reg[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_reg[i] <= sync_reg[i-1];
      end
      in_prev_reg  <= in_sync;
      edge_cap_reg <= edge_cap_next;
      irq_mask_reg <= irq_mask_next;
      // Built from the next-state values so a mask or W1C write drops irq
      // on the same edge that updates the registers.
      irq_reg      <= |(edge_cap_next & irq_mask_next);
    end
  end

  assign irq_mask = irq_mask_reg;
  assign edge_cap = edge_cap_reg;
  assign irq      = irq_reg;

endmodule

// File: rtl/controller_pio_ext.sv
// controller_pio_ext
// Avalon-MM PIO slave: OUT_WIDTH-bit output port with write/set/clear/toggle
// and hardware-timed one-shot pulses, plus an IN_WIDTH-bit synchronised input
// port with per-bit edge capture and a maskable level interrupt.
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   address      word address (DATA, OUT, IRQMASK, EDGECAP, SET, CLR, TGL, PULSE)
//   chipselect   slave select
//   write_n      active-low write strobe
//   writedata    write data
//   readdata     combinational read data, zero-extended
//   in_port      asynchronous inputs
//   out_port     registered outputs
//   irq          registered level interrupt
module controller_pio_ext
  import controller_pio_pkg::*;
#(
  parameter int                 OUT_WIDTH    = 11,
  parameter int                 IN_WIDTH     = 8,
  parameter logic [OUT_WIDTH-1:0] OUT_RESET  = '0,
  parameter int                 EDGE_TYPE    = EDGE_RISING,
  parameter int                 SYNC_STAGES  = 2,
  parameter int                 PULSE_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [2:0]           address,
  input  logic                 chipselect,
  input  logic                 write_n,
  input  logic [31:0]          writedata,
  output logic [31:0]          readdata,
  input  logic [IN_WIDTH-1:0]  in_port,
  output logic [OUT_WIDTH-1:0] out_port,
  output logic                 irq
);

  localparam int CNT_W = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_CYCLES - 1);

  logic                 wr;
  logic [OUT_WIDTH-1:0] wd_out;
  logic [IN_WIDTH-1:0]  wd_in;
  logic                 unused_wd;

  logic [OUT_WIDTH-1:0] out_reg, out_next;
  logic [OUT_WIDTH-1:0] pulse_mask_reg, pulse_mask_next;
  logic [CNT_W-1:0]     counter_reg, counter_next;
  pulse_state_t         state_reg, state_next;

  logic [IN_WIDTH-1:0]  in_sync;
  logic [IN_WIDTH-1:0]  irq_mask;
  logic [IN_WIDTH-1:0]  edge_cap;

  assign wr        = chipselect & ~write_n;
  // Bits above the port widths are dropped, so out-of-range writes do nothing.
  assign wd_out    = writedata[OUT_WIDTH-1:0];
  assign wd_in     = writedata[IN_WIDTH-1:0];
  assign unused_wd = ^writedata;

  pio_edge_capture #(
    .IN_WIDTH    (IN_WIDTH),
    .EDGE_TYPE   (EDGE_TYPE),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge_capture (
    .clk        (clk),
    .reset      (reset),
    .in_port    (in_port),
    .mask_we    (wr && (address == ADDR_IRQMASK)),
    .cap_w1c_we (wr && (address == ADDR_EDGECAP)),
    .wdata      (wd_in),
    .in_sync    (in_sync),
    .irq_mask   (irq_mask),
    .edge_cap   (edge_cap),
    .irq        (irq)
  );

  // Pulse engine and output register. Expiry is applied first, then the
  // CPU write; any bit the CPU writes leaves pulse ownership.
  always_comb begin
    out_next        = out_reg;
    pulse_mask_next = pulse_mask_reg;
    counter_next    = counter_reg;
    state_next      = state_reg;

    if (state_reg == PULSE_ACTIVE) begin
      if (counter_reg == '0) begin
        out_next        = out_next & ~pulse_mask_reg;
        pulse_mask_next = '0;
        state_next      = PULSE_IDLE;
      end else begin
        counter_next = counter_reg - CNT_W'(1);
      end
    end

    if (wr) begin
      case (address)
        ADDR_DATA, ADDR_OUT: begin
          out_next        = wd_out;
          pulse_mask_next = '0;
        end
        ADDR_SET: begin
          out_next        = out_next | wd_out;
          pulse_mask_next = pulse_mask_next & ~wd_out;
        end
        ADDR_CLR: begin
          out_next        = out_next & ~wd_out;
          pulse_mask_next = pulse_mask_next & ~wd_out;
        end
        ADDR_TGL: begin
          out_next        = out_next ^ wd_out;
          pulse_mask_next = pulse_mask_next & ~wd_out;
        end
        ADDR_PULSE: begin
          if (wd_out != '0) begin
            // Retrigger: bits of the old pulse not in the new mask drop now.
            out_next        = (out_next & ~pulse_mask_next) | wd_out;
            pulse_mask_next = wd_out;
            counter_next    = CNT_LOAD;
            state_next      = PULSE_ACTIVE;
          end
        end
        default: ;
      endcase
    end

    if (pulse_mask_next == '0) begin
      state_next = PULSE_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_reg        <= OUT_RESET;
      pulse_mask_reg <= '0;
      counter_reg    <= '0;
      state_reg      <= PULSE_IDLE;
    end else begin
      out_reg        <= out_next;
      pulse_mask_reg <= pulse_mask_next;
      counter_reg    <= counter_next;
      state_reg      <= state_next;
    end
  end

  assign out_port = out_reg;

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:    readdata[IN_WIDTH-1:0]  = in_sync;
      ADDR_OUT:     readdata[OUT_WIDTH-1:0] = out_reg;
      ADDR_IRQMASK: readdata[IN_WIDTH-1:0]  = irq_mask;
      ADDR_EDGECAP: readdata[IN_WIDTH-1:0]  = edge_cap;
      ADDR_PULSE: begin
        readdata[OUT_WIDTH-1:0] = pulse_mask_reg;
        readdata[31]            = readdata[31] | (state_reg == PULSE_ACTIVE);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_controller_pio_ext.sv
// Testbench for controller_pio_ext (default parameters). Expectations are
// queued with the cycle they are due; a negedge monitor pops and compares.
module tb_controller_pio_ext;
  import controller_pio_pkg::*;

  localparam int K_OUT = 0;
  localparam int K_IRQ = 1;
  localparam int K_RD  = 2;

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] val;
    string       tag;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  in_port;
  logic [10:0] out_port;
  logic        irq;

  int   cyc;
  int   n_checks;
  int   n_pass;
  exp_t sb[$];
  logic [31:0] mon_got;

  controller_pio_ext dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .out_port   (out_port),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Monitor: compare every queued expectation that is due this cycle.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        case (sb[i].kind)
          K_OUT:   mon_got = 32'(out_port);
          K_IRQ:   mon_got = 32'(irq);
          default: mon_got = readdata;
        endcase
        check(sb[i].tag, mon_got, sb[i].val);
        sb.delete(i);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input int dly, input int kind, input logic [31:0] v, input string tag);
    exp_t e;
    e.cyc  = cyc + dly;
    e.kind = kind;
    e.val  = v;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic rd_check(input logic [2:0] a, input logic [31:0] v, input string tag);
    address = a;
    expect_at(0, K_RD, v, tag);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    reset      = 1'b1;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = '0;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state
    expect_at(0, K_OUT, 32'h0, "rst_out");
    expect_at(0, K_IRQ, 32'h0, "rst_irq");
    for (int a = 0; a < 8; a++) rd_check(3'(a), 32'h0, $sformatf("rst_rd%0d", a));

    // OUT / SET / CLR / TGL in consecutive cycles
    expect_at(1, K_OUT, 32'h5A5, "out_wr");
    expect_at(2, K_OUT, 32'h5AF, "out_set");
    expect_at(3, K_OUT, 32'h5AA, "out_clr");
    expect_at(4, K_OUT, 32'h2AA, "out_tgl");
    wr(ADDR_OUT, 32'h5A5);
    wr(ADDR_SET, 32'h00A);
    wr(ADDR_CLR, 32'h005);
    wr(ADDR_TGL, 32'h700);
    wr(ADDR_SET, 32'hFFFF_F800);
    rd_check(ADDR_OUT, 32'h2AA, "oor_set");
    wr(ADDR_OUT, 32'h0);

    // Single pulse: high for 16 cycles, low on the 17th
    for (int d = 1; d <= 16; d++) expect_at(d, K_OUT, 32'h003, $sformatf("pulse_d%0d", d));
    expect_at(17, K_OUT, 32'h000, "pulse_end");
    wr(ADDR_PULSE, 32'h003);
    rd_check(ADDR_PULSE, 32'h8000_0003, "pulse_busy");
    repeat (16) tick();
    rd_check(ADDR_PULSE, 32'h0, "pulse_idle");

    // CPU takes ownership of bit 0 mid-pulse
    for (int d = 1; d <= 16; d++) expect_at(d, K_OUT, 32'h003, $sformatf("own_d%0d", d));
    expect_at(17, K_OUT, 32'h001, "own_exp");
    expect_at(19, K_OUT, 32'h001, "own_hold");
    wr(ADDR_PULSE, 32'h003);
    repeat (4) tick();
    wr(ADDR_SET, 32'h001);
    rd_check(ADDR_PULSE, 32'h8000_0002, "own_mask");
    repeat (12) tick();
    wr(ADDR_OUT, 32'h0);

    // Retrigger with a different mask
    expect_at(1,  K_OUT, 32'h003, "rtg_first");
    expect_at(10, K_OUT, 32'h003, "rtg_before");
    expect_at(11, K_OUT, 32'h004, "rtg_switch");
    expect_at(26, K_OUT, 32'h004, "rtg_last");
    expect_at(27, K_OUT, 32'h000, "rtg_end");
    wr(ADDR_PULSE, 32'h003);
    repeat (9) tick();
    wr(ADDR_PULSE, 32'h004);
    repeat (17) tick();
    rd_check(ADDR_PULSE, 32'h0, "rtg_idle");

    // PULSE with a zero mask is ignored
    expect_at(1, K_OUT, 32'h0, "pulse0_out");
    wr(ADDR_PULSE, 32'h0);
    rd_check(ADDR_PULSE, 32'h0, "pulse0_rd");

    // Reset in the middle of a pulse
    expect_at(1, K_OUT, 32'h7F0, "mid_pulse");
    wr(ADDR_PULSE, 32'h7F0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    expect_at(0, K_OUT, 32'h0, "mid_rst_out");
    rd_check(ADDR_PULSE, 32'h0, "mid_rst_pulse");

    // Rising edge on in_port[0] with mask bit 0 set
    wr(ADDR_IRQMASK, 32'h01);
    in_port = 8'h01;
    tick();
    tick();
    rd_check(ADDR_DATA, 32'h01, "in_sync");
    expect_at(1, K_IRQ, 32'h1, "irq_rise");
    rd_check(ADDR_EDGECAP, 32'h01, "edge_cap");
    rd_check(ADDR_IRQMASK, 32'h01, "irq_mask");

    // W1C in the same cycle as a new rising edge: edge wins
    in_port = 8'h00;
    repeat (3) tick();
    in_port = 8'h01;
    tick();
    tick();
    wr(ADDR_EDGECAP, 32'h01);
    expect_at(0, K_IRQ, 32'h1, "w1c_race_irq");
    rd_check(ADDR_EDGECAP, 32'h01, "w1c_race");

    // W1C alone clears the bit and irq falls
    expect_at(2, K_IRQ, 32'h0, "irq_fall");
    wr(ADDR_EDGECAP, 32'h01);
    rd_check(ADDR_EDGECAP, 32'h00, "w1c_clear");

    for (int i = 0; i < 40 && sb.size() > 0; i++) tick();
    check("sb_empty", 32'(sb.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
